// File: rtl/OpCodes.sv
// Shared LDST datapath constants: lane data width is NSIG+1, lanes per vector request.
package OpCodes;
  localparam int NSIG          = 7;
  localparam int REGLD_PER_CLK = 4;
endpackage

// File: rtl/ldst_mem_pkg.sv
// Types shared by the LDST memory responder and its request FIFO.
package ldst_mem_pkg;
  import OpCodes::*;

  localparam int unsigned LDST_ADDR_W = 8;
  localparam int unsigned LDST_TAG_W  = 4;

  typedef logic [NSIG:0] lane_data_t;

  typedef struct packed {
    logic                                      store;
    logic [REGLD_PER_CLK-1:0]                  mask;
    logic [REGLD_PER_CLK-1:0][LDST_ADDR_W-1:0] addr;
    lane_data_t [REGLD_PER_CLK-1:0]            wdata;
    logic [LDST_TAG_W-1:0]                     tag;
  } ldst_req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/ldst_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit to tell full from empty.
module ldst_req_fifo
  import ldst_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  ldst_req_t din,
  input  logic      pop,
  output ldst_req_t dout,
  output logic      full,
  output logic      empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  ldst_req_t      mem [DEPTH];
  logic [PW:0]    wr_ptr;
  logic [PW:0]    rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign dout  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !full) mem[wr_ptr[PW-1:0]] <= din;
  end
endmodule

// File: rtl/ldst_mem_responder.sv
// Memory-side responder for LDST vector requests: in-order, fixed-latency access to a
// word array with one response (load data or store ack) per request.
module ldst_mem_responder
  import OpCodes::*;
  import ldst_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 256,
  parameter int unsigned ADDR_W     = LDST_ADDR_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned TAG_W      = LDST_TAG_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_store,
  input  logic [REGLD_PER_CLK-1:0]             req_mask,
  input  logic [REGLD_PER_CLK-1:0][ADDR_W-1:0] req_addr,
  input  logic [REGLD_PER_CLK-1:0][NSIG:0]     req_wdata,
  input  logic [TAG_W-1:0]                     req_tag,
  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic                                 resp_store,
  output logic [TAG_W-1:0]                     resp_tag,
  output logic [REGLD_PER_CLK-1:0][NSIG:0]     resp_rdata,
  output logic                                 resp_err
);
  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q;
  ldst_req_t                      work_q;
  ldst_req_t                      fifo_din, fifo_dout;
  logic                           fifo_full, fifo_empty, push, pop, access;
  lane_data_t                     mem [MEM_WORDS];
  lane_data_t [REGLD_PER_CLK-1:0] rd_lanes;
  logic [REGLD_PER_CLK-1:0]       lane_ok;
  logic                           any_err;

  assign req_ready  = !rst && !fifo_full;
  assign push       = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign access     = (state_q == WAIT) && (cnt_q == CNT_W'(1));

  always_comb begin
    fifo_din       = '0;
    fifo_din.store = req_store;
    fifo_din.mask  = req_mask;
    fifo_din.tag   = LDST_TAG_W'(req_tag);
    for (int unsigned i = 0; i < REGLD_PER_CLK; i++) begin
      fifo_din.addr[i]  = LDST_ADDR_W'(req_addr[i]);
      fifo_din.wdata[i] = req_wdata[i];
    end
  end

  ldst_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (cnt_q == CNT_W'(1)) state_d = RESP;
      RESP: if (resp_ready) begin
        pop     = !fifo_empty;
        state_d = fifo_empty ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Masked-off and out-of-range lanes read as zero; only in-range active lanes may write.
  always_comb begin
    rd_lanes = '0;
    lane_ok  = '0;
    any_err  = 1'b0;
    for (int unsigned i = 0; i < REGLD_PER_CLK; i++) begin
      if (work_q.mask[i]) begin
        if (32'(work_q.addr[i]) < MEM_WORDS) begin
          lane_ok[i]  = 1'b1;
          rd_lanes[i] = mem[work_q.addr[i][IDX_W-1:0]];
        end else begin
          any_err = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      resp_store <= 1'b0;
      resp_tag   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        work_q <= fifo_dout;
        cnt_q  <= CNT_W'(MEM_LAT);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (access) begin
        resp_store <= work_q.store;
        resp_tag   <= TAG_W'(work_q.tag);
        resp_err   <= any_err;
        resp_rdata <= work_q.store ? '0 : rd_lanes;
      end
    end
  end

  // Ascending lane order makes the highest-numbered lane win on address conflicts.
  always_ff @(posedge clk) begin
    if (!rst && access && work_q.store) begin
      for (int unsigned i = 0; i < REGLD_PER_CLK; i++) begin
        if (lane_ok[i]) mem[work_q.addr[i][IDX_W-1:0]] <= work_q.wdata[i];
      end
    end
  end
endmodule

// File: tb/tb_ldst_mem_responder.sv
// Scoreboard bench for ldst_mem_responder: directed cases plus randomized traffic against a flat array model.
module tb_ldst_mem_responder;
  import OpCodes::*;
  import ldst_mem_pkg::*;

  localparam int unsigned MW    = 200;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 2;
  localparam int unsigned TW    = 4;
  localparam int unsigned NL    = REGLD_PER_CLK;
  localparam int unsigned DW    = NSIG + 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     req_valid, req_ready, req_store;
  logic [NL-1:0]            req_mask;
  logic [NL-1:0][AW-1:0]    req_addr;
  logic [NL-1:0][DW-1:0]    req_wdata;
  logic [TW-1:0]            req_tag;
  logic                     resp_valid, resp_ready, resp_store, resp_err;
  logic [TW-1:0]            resp_tag;
  logic [NL-1:0][DW-1:0]    resp_rdata;

  ldst_mem_responder #(
    .MEM_WORDS  (MW),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH),
    .MEM_LAT    (LAT),
    .TAG_W      (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_mask   (req_mask),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_store (resp_store),
    .resp_tag   (resp_tag),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             store;
    logic [TW-1:0]    tag;
    logic             err;
    logic [NL*DW-1:0] rdata;
    logic [NL*DW-1:0] care;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [NL*DW-1:0] mon_rd;
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] model_mem [MW];
  bit            written   [MW];
  int unsigned   cyc = 0;
  int            rr_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = 1'b0;
      default: resp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: each request is applied to the flat array in issue order.
  function automatic void model_issue(input logic st, input logic [NL-1:0] m,
                                      input logic [NL*AW-1:0] a, input logic [NL*DW-1:0] d,
                                      input logic [TW-1:0] t);
    exp_t e;
    e.store = st;
    e.tag   = t;
    e.err   = 1'b0;
    e.rdata = '0;
    e.care  = '0;
    for (int i = 0; i < int'(NL); i++) begin
      logic [AW-1:0] ad;
      logic [DW-1:0] wd;
      ad = a[i*AW +: AW];
      wd = d[i*DW +: DW];
      if (!st) e.care[i*DW +: DW] = '1;
      if (m[i]) begin
        if (32'(ad) >= MW) e.err = 1'b1;
        else if (st) begin
          model_mem[ad] = wd;
          written[ad]   = 1'b1;
        end else begin
          e.rdata[i*DW +: DW] = model_mem[ad];
          if (!written[ad]) e.care[i*DW +: DW] = '0;
        end
      end
    end
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got tag %0h, want no response", resp_tag);
      end else begin
        mon_e  = exp_q[0];
        mon_rd = resp_rdata;
        chk("resp_tag",   64'(resp_tag),   64'(mon_e.tag));
        chk("resp_store", 64'(resp_store), 64'(mon_e.store));
        chk("resp_err",   64'(resp_err),   64'(mon_e.err));
        chk("resp_rdata", 64'(mon_rd & mon_e.care), 64'(mon_e.rdata & mon_e.care));
        if (resp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic st, input logic [NL-1:0] m, input logic [NL*AW-1:0] a,
                      input logic [NL*DW-1:0] d, input logic [TW-1:0] t, input bit track,
                      output int unsigned acc_cyc);
    int unsigned guard;
    guard = 0;
    acc_cyc = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_store = st;
    req_mask  = m;
    req_addr  = a;
    req_wdata = d;
    req_tag   = t;
    while (!req_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got req_ready 0, want 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    if (track) model_issue(st, m, a, d, t);
  endtask

  task automatic drain(input string name);
    int unsigned g;
    g = 0;
    while ((exp_q.size() != 0 || resp_valid) && g < 600) begin
      @(negedge clk);
      g++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [NL*AW-1:0] a;
    logic [NL*DW-1:0] d;
    int unsigned      acc, g;

    rst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_mask = '0;
    req_addr = '0; req_wdata = '0; req_tag = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  64'(req_ready),  64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_tag",   64'(resp_tag),   64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_resp_err",   64'(resp_err),   64'd0);
    chk("rst_resp_store", 64'(resp_store), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Store lanes i -> A0+i, then load them back.
    for (int i = 0; i < int'(NL); i++) begin
      a[i*AW +: AW] = AW'(i);
      d[i*DW +: DW] = DW'(8'hA0 + i);
    end
    send(1'b1, '1, a, d, 4'd1, 1'b1, acc);
    send(1'b0, '1, a, '0, 4'd2, 1'b1, acc);
    drain("drain_store_load");

    // Latency from acceptance to resp_valid with an idle responder.
    send(1'b0, '1, a, '0, 4'd3, 1'b1, acc);
    g = 0;
    while (!resp_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("latency", 64'(cyc - acc), 64'(LAT + 1));
    drain("drain_latency");

    // Backpressure: five loads fill work register plus FIFO.
    rr_mode = 1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) send(1'b0, '1, a, '0, TW'(4 + k), 1'b1, acc);
    @(negedge clk);
    chk("req_ready_full", 64'(req_ready), 64'd0);
    repeat (5) @(negedge clk);
    chk("req_ready_still_full", 64'(req_ready), 64'd0);
    rr_mode = 0;
    send(1'b0, '1, a, '0, 4'd9, 1'b1, acc);
    drain("drain_backpressure");

    // Lane edge cases with an out-of-range address on lane 2.
    a = {AW'(3), AW'(MW), AW'(2), AW'(1)};
    send(1'b0, 4'b0101, a, '0, 4'd10, 1'b1, acc);
    send(1'b0, 4'b0100, a, '0, 4'd11, 1'b1, acc);
    a = {AW'(3), AW'(2), AW'(1), AW'(0)};
    send(1'b0, 4'b0101, a, '0, 4'd12, 1'b1, acc);
    send(1'b0, 4'b0000, a, '0, 4'd13, 1'b1, acc);
    send(1'b1, 4'b1000, {AW'(MW), AW'(0), AW'(0), AW'(0)}, {DW'(8'h77), DW'(0), DW'(0), DW'(0)}, 4'd14, 1'b1, acc);
    drain("drain_lanes");

    // Same-address store conflict: lane 1 must win.
    send(1'b1, 4'b0011, {AW'(0), AW'(0), AW'(5), AW'(5)}, {DW'(0), DW'(0), DW'(22), DW'(11)}, 4'd1, 1'b1, acc);
    send(1'b0, 4'b0001, {AW'(0), AW'(0), AW'(0), AW'(5)}, '0, 4'd2, 1'b1, acc);
    drain("drain_conflict");

    // Reset one cycle after accepting a store: it must neither respond nor write.
    send(1'b1, 4'b0001, {AW'(0), AW'(0), AW'(0), AW'(7)}, {DW'(0), DW'(0), DW'(0), DW'(33)}, 4'd3, 1'b1, acc);
    drain("drain_pre_reset");
    send(1'b1, 4'b0001, {AW'(0), AW'(0), AW'(0), AW'(7)}, {DW'(0), DW'(0), DW'(0), DW'(55)}, 4'd4, 1'b0, acc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_resp_after_reset", 64'(resp_valid), 64'd0);
    end
    send(1'b0, 4'b0001, {AW'(0), AW'(0), AW'(0), AW'(7)}, '0, 4'd5, 1'b1, acc);
    drain("drain_post_reset");

    // Randomized traffic with random response backpressure.
    rr_mode = 2;
    for (int k = 0; k < 80; k++) begin
      for (int i = 0; i < int'(NL); i++) begin
        a[i*AW +: AW] = ($urandom_range(0, 5) == 0) ? AW'($urandom_range(MW, 255))
                                                    : AW'($urandom_range(0, 15));
        d[i*DW +: DW] = DW'($urandom);
      end
      send(1'($urandom_range(0, 1)), NL'($urandom), a, d, TW'($urandom), 1'b1, acc);
    end
    drain("drain_random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
